// File: rtl/ternary_pkg.sv
// Shared definitions for the balanced-ternary logic pipe: trit encodings,
// opcode and FSM state enums, and single-trit min/max/negate helpers.
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_NEG  = 2'b01;
  localparam logic [1:0] TRIT_POS  = 2'b10;
  localparam logic [1:0] TRIT_INV  = 2'b11;

  typedef enum logic [3:0] {
    OpAnd       = 4'd0,
    OpOr        = 4'd1,
    OpNot       = 4'd2,
    OpNand      = 4'd3,
    OpNor       = 4'd4,
    OpXor       = 4'd5,
    OpConsensus = 4'd6,
    OpMajority  = 4'd7,
    OpAny       = 4'd8,
    OpAll       = 4'd9,
    OpShl       = 4'd10,
    OpShr       = 4'd11,
    OpRol       = 4'd12,
    OpRor       = 4'd13,
    OpReverse   = 4'd14,
    OpFlip      = 4'd15
  } tlu_op_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } tlu_state_e;

  // Invalid encoding behaves as ZERO everywhere.
  function automatic logic [1:0] trit_norm(logic [1:0] t);
    return (t == TRIT_INV) ? TRIT_ZERO : t;
  endfunction

  // Ordering is NEG < ZERO < POS.
  function automatic logic [1:0] trit_min(logic [1:0] a, logic [1:0] b);
    logic [1:0] na;
    logic [1:0] nb;
    na = trit_norm(a);
    nb = trit_norm(b);
    if (na == TRIT_NEG || nb == TRIT_NEG) return TRIT_NEG;
    if (na == TRIT_ZERO || nb == TRIT_ZERO) return TRIT_ZERO;
    return TRIT_POS;
  endfunction

  function automatic logic [1:0] trit_max(logic [1:0] a, logic [1:0] b);
    logic [1:0] na;
    logic [1:0] nb;
    na = trit_norm(a);
    nb = trit_norm(b);
    if (na == TRIT_POS || nb == TRIT_POS) return TRIT_POS;
    if (na == TRIT_ZERO || nb == TRIT_ZERO) return TRIT_ZERO;
    return TRIT_NEG;
  endfunction

  function automatic logic [1:0] trit_neg(logic [1:0] a);
    case (trit_norm(a))
      TRIT_NEG: return TRIT_POS;
      TRIT_POS: return TRIT_NEG;
      default:  return TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/tlu_trit_alu.sv
// Combinational single-trit evaluator for the trit-wise logic opcodes 0-9.
// Opcodes outside that range yield ZERO; the parent handles them.
module tlu_trit_alu
  import ternary_pkg::*;
(
  input  tlu_op_e    op_i,
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] c_i,
  output logic [1:0] y_o
);

  logic [1:0] a, b, c;
  logic [1:0] n_pos, n_neg;

  assign a = trit_norm(a_i);
  assign b = trit_norm(b_i);
  assign c = trit_norm(c_i);

  // Per-opcode trit result.
  always_comb begin
    y_o   = TRIT_ZERO;
    n_pos = {1'b0, a == TRIT_POS} + {1'b0, b == TRIT_POS} + {1'b0, c == TRIT_POS};
    n_neg = {1'b0, a == TRIT_NEG} + {1'b0, b == TRIT_NEG} + {1'b0, c == TRIT_NEG};
    case (op_i)
      OpAnd:  y_o = trit_min(a, b);
      OpOr:   y_o = trit_max(a, b);
      OpNot:  y_o = trit_neg(a);
      OpNand: y_o = trit_neg(trit_min(a, b));
      OpNor:  y_o = trit_neg(trit_max(a, b));
      OpXor:  y_o = trit_max(trit_min(a, trit_neg(b)), trit_min(trit_neg(a), b));
      OpConsensus: begin
        if (a == b)      y_o = a;
        else if (b == c) y_o = b;
        else if (a == c) y_o = a;
        else             y_o = TRIT_ZERO;
      end
      OpMajority: begin
        // sign(a+b+c) reduces to comparing the POS and NEG counts.
        if (n_pos > n_neg)      y_o = TRIT_POS;
        else if (n_neg > n_pos) y_o = TRIT_NEG;
        else                    y_o = TRIT_ZERO;
      end
      OpAny: y_o = (a != TRIT_ZERO || b != TRIT_ZERO) ? TRIT_POS : TRIT_ZERO;
      OpAll: y_o = (a != TRIT_ZERO && b != TRIT_ZERO) ? TRIT_POS : TRIT_ZERO;
      default: y_o = TRIT_ZERO;
    endcase
  end

endmodule

// File: rtl/ternary_logic_pipe.sv
// Handshaked balanced-ternary logic unit. Logic ops finish in one cycle;
// shift/rotate ops step one trit per cycle through a working register.
// Optional invalid-trit flag enabled by defining TLU_INVALID_TRIT_CHECK_EN.
module ternary_logic_pipe
  import ternary_pkg::*;
#(
  parameter int unsigned TRITS = 18,
  parameter int unsigned SHW   = $clog2(TRITS) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [2*TRITS-1:0] operand_a,
  input  logic [2*TRITS-1:0] operand_b,
  input  logic [2*TRITS-1:0] operand_c,
  input  logic [SHW-1:0]     shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*TRITS-1:0] result,
  output logic               out_err
);

  localparam int unsigned W = 2 * TRITS;

  tlu_op_e    op_e;
  tlu_state_e state_q, state_d;
  tlu_op_e    shift_op_q, shift_op_d;
  logic [W-1:0]   work_q, work_d;
  logic [SHW-1:0] count_q, count_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   result_q, result_d;

  logic [W-1:0] alu_y, rev_y, flip_y, norm_a, logic_y, step_y, load_y;
  logic         is_shift, accept, drain, load;

  assign op_e     = tlu_op_e'(op);
  assign is_shift = op_e inside {OpShl, OpShr, OpRol, OpRor};
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign result    = result_q;

  for (genvar g = 0; g < TRITS; g++) begin : g_alu
    tlu_trit_alu u_trit_alu (
      .op_i (op_e),
      .a_i  (operand_a[2*g +: 2]),
      .b_i  (operand_b[2*g +: 2]),
      .c_i  (operand_c[2*g +: 2]),
      .y_o  (alu_y[2*g +: 2])
    );
  end

  // Whole-word ops handled here: normalise, reverse, flip.
  always_comb begin
    norm_a = '0;
    rev_y  = '0;
    flip_y = '0;
    for (int unsigned i = 0; i < TRITS; i++) begin
      norm_a[2*i +: 2] = trit_norm(operand_a[2*i +: 2]);
      rev_y[2*i +: 2]  = trit_norm(operand_a[2*(TRITS-1-i) +: 2]);
      flip_y[2*i +: 2] = trit_neg(operand_a[2*i +: 2]);
    end
  end

  // Single-cycle result; a zero-amount shift/rotate passes operand_a through.
  always_comb begin
    logic_y = alu_y;
    case (op_e)
      OpReverse:                    logic_y = rev_y;
      OpFlip:                       logic_y = flip_y;
      OpShl, OpShr, OpRol, OpRor:   logic_y = norm_a;
      default:                      logic_y = alu_y;
    endcase
  end

  // One-trit move of the working register.
  always_comb begin
    step_y = work_q;
    case (shift_op_q)
      OpShl:   step_y = {work_q[W-3:0], 2'b00};
      OpShr:   step_y = {2'b00, work_q[W-1:2]};
      OpRol:   step_y = {work_q[W-3:0], work_q[W-1:W-2]};
      default: step_y = {work_q[1:0], work_q[W-1:2]};
    endcase
  end

  // FSM next state and output-register load control.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    count_d    = count_q;
    shift_op_d = shift_op_q;
    load       = 1'b0;
    load_y     = logic_y;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            work_d     = norm_a;
            count_d    = shamt;
            shift_op_d = op_e;
            state_d    = StShift;
          end else begin
            load   = 1'b1;
            load_y = logic_y;
          end
        end
      end
      StShift: begin
        work_d  = step_y;
        count_d = count_q - SHW'(1);
        // Output register is guaranteed free here, so completion never stalls.
        if (count_q == SHW'(1)) begin
          load    = 1'b1;
          load_y  = step_y;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register: holds while stalled, clears on drain unless reloaded.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (drain) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = load_y;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_op_q  <= OpShl;
      work_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      shift_op_q  <= shift_op_d;
      work_q      <= work_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

`ifdef TLU_INVALID_TRIT_CHECK_EN
  logic [TRITS-1:0] inv_a, inv_b, inv_c;
  logic             err_now;
  logic             err_pend_q, err_pend_d;
  logic             err_q, err_d;

  // Flag any 11 trit in the operands the op actually reads.
  always_comb begin
    inv_a   = '0;
    inv_b   = '0;
    inv_c   = '0;
    err_now = 1'b0;
    for (int unsigned i = 0; i < TRITS; i++) begin
      inv_a[i] = &operand_a[2*i +: 2];
      inv_b[i] = &operand_b[2*i +: 2];
      inv_c[i] = &operand_c[2*i +: 2];
    end
    case (op_e)
      OpAnd, OpOr, OpNand, OpNor, OpXor, OpAny, OpAll: err_now = |{inv_a, inv_b};
      OpConsensus, OpMajority:                         err_now = |{inv_a, inv_b, inv_c};
      default:                                         err_now = |inv_a;
    endcase
  end

  // Shift ops latch their flag at accept and release it with the result.
  always_comb begin
    err_pend_d = err_pend_q;
    err_d      = err_q;
    if (state_q == StIdle && accept) err_pend_d = err_now;
    if (load) err_d = (state_q == StShift) ? err_pend_q : err_now;
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_logic_pipe.sv
// Self-checking bench for ternary_logic_pipe: directed timing cases plus a
// randomized scoreboard run against an integer-valued trit model.
module tb_ternary_logic_pipe;

  localparam int unsigned TRITS = 18;
  localparam int unsigned SHW   = $clog2(TRITS) + 1;
  localparam int unsigned W     = 2 * TRITS;
`ifdef TLU_INVALID_TRIT_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [3:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0, c = '0;
  logic [SHW-1:0] shamt = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   result;
  logic           out_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ternary_logic_pipe #(.TRITS(TRITS), .SHW(SHW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (a),
    .operand_b (b),
    .operand_c (c),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_err   (out_err)
  );

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: trits as integers -1/0/+1.
  function automatic int tv(logic [1:0] t);
    case (t)
      2'b01:   return -1;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] te(int v);
    if (v > 0) return 2'b10;
    if (v < 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int mn(int x, int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int mx(int x, int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [W-1:0] model_res(int o, logic [W-1:0] ma, logic [W-1:0] mb,
                                             logic [W-1:0] mc, int sh);
    logic [W-1:0] r;
    int t;
    t = TRITS;
    r = '0;
    for (int i = 0; i < t; i++) begin
      int x, y, z, v;
      x = tv(ma[2*i +: 2]);
      y = tv(mb[2*i +: 2]);
      z = tv(mc[2*i +: 2]);
      v = 0;
      case (o)
        0:  v = mn(x, y);
        1:  v = mx(x, y);
        2:  v = -x;
        3:  v = -mn(x, y);
        4:  v = -mx(x, y);
        5:  v = mx(mn(x, -y), mn(-x, y));
        6:  v = (x == y) ? x : (y == z) ? y : (x == z) ? x : 0;
        7:  v = x + y + z;
        8:  v = (x != 0 || y != 0) ? 1 : 0;
        9:  v = (x != 0 && y != 0) ? 1 : 0;
        10: v = (i - sh >= 0) ? tv(ma[2*(i-sh) +: 2]) : 0;
        11: v = (i + sh < t) ? tv(ma[2*(i+sh) +: 2]) : 0;
        12: v = tv(ma[2*(((i - sh) % t + t) % t) +: 2]);
        13: v = tv(ma[2*((i + sh) % t) +: 2]);
        14: v = tv(ma[2*(t-1-i) +: 2]);
        default: v = -x;
      endcase
      r[2*i +: 2] = te(v);
    end
    return r;
  endfunction

  function automatic bit has_inv(logic [W-1:0] v);
    for (int i = 0; i < TRITS; i++) if (v[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_err(int o, logic [W-1:0] ma, logic [W-1:0] mb,
                                     logic [W-1:0] mc);
    bit e;
    if (o == 6 || o == 7)    e = has_inv(ma) || has_inv(mb) || has_inv(mc);
    else if (o <= 9 && o != 2) e = has_inv(ma) || has_inv(mb);
    else                     e = has_inv(ma);
    return CheckEn && e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < TRITS; i++) begin
      int u;
      u = $urandom_range(15);
      r[2*i +: 2] = (u == 0) ? 2'b11 : (u < 6) ? 2'b00 : (u < 11) ? 2'b01 : 2'b10;
    end
    return r;
  endfunction

  // Issue one op with out_ready high, measure latency and check the result.
  task automatic run_one(string tag, int o, logic [W-1:0] ta, logic [W-1:0] tb_,
                         logic [W-1:0] tc, int sh, int exp_lat, bit check_busy);
    int lat;
    bit busy_ok;
    @(negedge clk);
    in_valid = 1'b1; op = o[3:0]; a = ta; b = tb_; c = tc; shamt = sh[SHW-1:0];
    out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    #1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    if (check_busy) check_eq({tag, "_busy"}, busy_ok, 1);
    check_eq({tag, "_result"}, result, model_res(o, ta, tb_, tc, sh));
    check_eq({tag, "_err"}, out_err, model_err(o, ta, tb_, tc));
  endtask

  initial begin
    logic [W:0]   q[$];
    logic [W:0]   exp;
    logic [W-1:0] ra, rb, rc, held;
    int           ro, rs, sent;
    bit           flag;

    // Reset values.
    @(negedge clk);
    #1 check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_out_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", in_ready, 1);

    // Directed test-plan cases.
    run_one("and", 0, 36'hAAAAAAAAA, 36'h555555555, '0, 0, 1, 1'b0);
    check_eq("and_const", result, 36'h555555555);
    run_one("rol3", 12, 36'h000000001, '0, '0, 3, 4, 1'b1);
    check_eq("rol3_const", result, 36'h000000040);
    run_one("ror19", 13, 36'h000000001, '0, '0, 19, 20, 1'b1);
    check_eq("ror19_const", result, 36'h400000000);
    run_one("shr20", 11, 36'hAAAAAAAAA, '0, '0, 20, 21, 1'b1);
    check_eq("shr20_const", result, 36'h000000000);
    run_one("shl0", 10, rand_word(), '0, '0, 0, 1, 1'b0);
    run_one("rev", 14, rand_word(), '0, '0, 0, 1, 1'b0);
    run_one("not_inv", 2, 36'h000000003, '0, '0, 0, 1, 1'b0);
    check_eq("not_inv_result", result, 0);
    check_eq("not_inv_err", out_err, CheckEn);

    // Back-to-back MAJORITY, one result per cycle.
    out_ready = 1'b1;
    exp = '0;
    flag = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd7;
      a = {rand_word()} & ~36'h3 | 36'h2;
      b = {rand_word()} & ~36'h3 | 36'h2;
      c = {rand_word()} & ~36'h3 | 36'h1;
      #1;
      if (!in_ready) flag = 1'b0;
      if (k > 0) begin
        check_eq("maj_valid", out_valid, 1);
        check_eq("maj_result", result, exp[W-1:0]);
      end
      exp = {1'b0, model_res(7, a, b, c, 0)};
      check_eq("maj_trit0", exp[1:0], 2'b10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_eq("maj_last_valid", out_valid, 1);
    check_eq("maj_last_result", result, exp[W-1:0]);
    check_eq("maj_in_ready_held", flag, 1);

    // Output stall: result held, in_ready low, then released with out_ready.
    @(negedge clk);
    ra = rand_word(); rb = rand_word();
    in_valid = 1'b1; op = 4'd1; a = ra; b = rb; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_eq("stall_valid", out_valid, 1);
    held = result;
    check_eq("stall_result", held, model_res(1, ra, rb, '0, 0));
    flag = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) flag = 1'b0;
    end
    check_eq("stall_hold", flag, 1);
    @(negedge clk);
    out_ready = 1'b1;
    #1 check_eq("stall_in_ready_rise", in_ready, 1);
    @(negedge clk);
    #1 check_eq("stall_drained", out_valid, 0);

    // Reset in the middle of a 10-trit rotate.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd12; a = rand_word(); shamt = SHW'(10);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("midrst_in_ready", in_ready, 1);
    flag = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) flag = 1'b0;
    end
    check_eq("midrst_no_output", flag, 1);

    // Randomized traffic against a scoreboard.
    sent = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (sent < 300 && $urandom_range(9) < 7) begin
        ro = $urandom_range(15);
        rs = (ro >= 10 && ro <= 13) ? $urandom_range(25) : $urandom_range(63);
        ra = rand_word(); rb = rand_word(); rc = rand_word();
        in_valid = 1'b1; op = ro[3:0]; a = ra; b = rb; c = rc; shamt = rs[SHW-1:0];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (sent >= 300) || ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("rnd_unexpected", out_valid, 0);
        end else begin
          exp = q.pop_front();
          check_eq("rnd_result", result, exp[W-1:0]);
          check_eq("rnd_err", out_err, exp[W]);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({model_err(ro, ra, rb, rc), model_res(ro, ra, rb, rc, rs)});
        sent++;
      end
      if (sent >= 300 && q.size() == 0) break;
    end
    in_valid = 1'b0;
    check_eq("rnd_all_sent", sent, 300);
    check_eq("rnd_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
